// File: rtl/ecc_2bit_stream_rx_pkg.sv
// ============================================================================
// Module   : ecc_2bit_stream_rx_pkg
// Purpose  : Shared constants and helpers for the 2-bit ECC link
//            (codeword layout, decoder flag encodings, encoder function).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ecc_2bit_stream_rx_pkg;

  localparam int CODE_W = 6;
  localparam int DATA_W = 2;

  localparam logic [2:0] FLAG_OK     = 3'b001;
  localparam logic [2:0] FLAG_CORR   = 3'b010;
  localparam logic [2:0] FLAG_UNCORR = 3'b100;

  // Distance-4 code: {d1, d0, d1, d0, d1^d0, d1^d0}.
  // Codewords 000000 / 010111 / 101011 / 111100 differ pairwise in 4 bits,
  // so any single-bit error is correctable and any double error is detected.
  function automatic logic [CODE_W-1:0] ecc_encode_2bit(input logic [DATA_W-1:0] d);
    logic p;
    p = d[1] ^ d[0];
    return {d[1], d[0], d[1], d[0], p, p};
  endfunction

  // Number of set bits in a codeword-sized vector.
  function automatic logic [2:0] popcount6(input logic [CODE_W-1:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < CODE_W; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ecc_2bit_stream_rx_decode.sv
// ============================================================================
// Module   : ecc_2bit_stream_rx_decode
// Purpose  : Combinational 2-bit ECC decoder. Returns the nearest data value
//            and a one-hot flag: OK (exact), CORR (1-bit error fixed) or
//            UNCORR (>=2 bit errors; raw code bits [5:4] are returned).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ecc_2bit_stream_rx_decode
  import ecc_2bit_stream_rx_pkg::*;
(
  input  logic [CODE_W-1:0] i_code,
  output logic [DATA_W-1:0] o_data,
  output logic [2:0]        o_flag
);

  logic [2:0] w_dist;

  // Minimum-distance search over the four codewords; at most one can be within 1.
  always_comb begin
    o_data = i_code[CODE_W-1 -: DATA_W];
    o_flag = FLAG_UNCORR;
    w_dist = 3'd0;
    for (int k = 0; k < 4; k++) begin
      w_dist = popcount6(i_code ^ ecc_encode_2bit(DATA_W'(k)));
      if (w_dist <= 3'd1) begin
        o_data = DATA_W'(k);
        o_flag = (w_dist == 3'd0) ? FLAG_OK : FLAG_CORR;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ecc_2bit_stream_rx.sv
// ============================================================================
// Module   : ecc_2bit_stream_rx
// Purpose  : Receive side of the 2-bit ECC link. Decodes a valid/ready stream
//            of 6-bit codewords, packs SYMS corrected symbols per output word,
//            and keeps saturating error counters plus a sticky alarm.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ecc_2bit_stream_rx
  import ecc_2bit_stream_rx_pkg::*;
#(
  parameter int SYMS  = 4,
  parameter int CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CODE_W-1:0]   in_code,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [2*SYMS-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_corrected,
  output logic                out_uncorr,
  input  logic                clr_counts,
  output logic [CNT_W-1:0]    corr_count,
  output logic [CNT_W-1:0]    uncorr_count,
  output logic                uncorr_alarm
);

  localparam int               IDX_W    = (SYMS > 2) ? $clog2(SYMS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SYMS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Decoder ahead of S1
  logic [DATA_W-1:0] w_dec_data;
  logic [2:0]        w_dec_flag;
  logic              w_dec_corr;
  logic              w_dec_uncorr;

  ecc_2bit_stream_rx_decode u_decode (
    .i_code (in_code),
    .o_data (w_dec_data),
    .o_flag (w_dec_flag)
  );

  // Anything that is neither OK nor CORR is treated as uncorrectable.
  assign w_dec_corr   = (w_dec_flag == FLAG_CORR);
  assign w_dec_uncorr = (w_dec_flag != FLAG_OK) && (w_dec_flag != FLAG_CORR);

  // S1 stage
  logic              r_s1_valid;
  logic [DATA_W-1:0] r_s1_data;
  logic              r_s1_corr;
  logic              r_s1_uncorr;

  // Packer state
  logic [IDX_W-1:0]  r_sym_idx;
  logic [2*SYMS-1:0] r_acc;
  logic              r_acc_corr;
  logic              r_acc_uncorr;
  logic [2*SYMS-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_out_corr;
  logic              r_out_uncorr;

  // Statistics
  logic [CNT_W-1:0]  r_corr_count;
  logic [CNT_W-1:0]  r_uncorr_count;
  logic              r_alarm;

  logic              w_accept;
  logic              w_last;
  logic              w_out_free;
  logic              w_s1_consume;
  logic [2*SYMS-1:0] w_sym_shifted;

  assign w_last        = (r_sym_idx == LAST_IDX);
  assign w_out_free    = !r_out_valid || out_ready;
  // Middle symbols always drain into acc; the closing symbol needs the out register.
  assign w_s1_consume  = r_s1_valid && (!w_last || w_out_free);
  // in_ready depends only on state and out_ready, never on in_valid.
  assign in_ready      = !r_s1_valid || w_s1_consume;
  assign w_accept      = in_valid && in_ready;
  assign w_sym_shifted = {{(2*SYMS-DATA_W){1'b0}}, r_s1_data} << {r_sym_idx, 1'b0};

  // S1 register: captures the decoded symbol on accept, empties when consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_data   <= '0;
      r_s1_corr   <= 1'b0;
      r_s1_uncorr <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid  <= 1'b1;
      r_s1_data   <= w_dec_data;
      r_s1_corr   <= w_dec_corr;
      r_s1_uncorr <= w_dec_uncorr;
    end else if (w_s1_consume) begin
      r_s1_valid  <= 1'b0;
    end
  end

  // Packer: accumulate symbols, hand a full word to the out register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sym_idx    <= '0;
      r_acc        <= '0;
      r_acc_corr   <= 1'b0;
      r_acc_uncorr <= 1'b0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_out_corr   <= 1'b0;
      r_out_uncorr <= 1'b0;
    end else if (w_s1_consume && w_last) begin
      r_out_data   <= r_acc | w_sym_shifted;
      r_out_corr   <= r_acc_corr | r_s1_corr;
      r_out_uncorr <= r_acc_uncorr | r_s1_uncorr;
      r_out_valid  <= 1'b1;
      r_acc        <= '0;
      r_acc_corr   <= 1'b0;
      r_acc_uncorr <= 1'b0;
      r_sym_idx    <= '0;
    end else begin
      if (w_s1_consume) begin
        r_acc        <= r_acc | w_sym_shifted;
        r_acc_corr   <= r_acc_corr | r_s1_corr;
        r_acc_uncorr <= r_acc_uncorr | r_s1_uncorr;
        r_sym_idx    <= r_sym_idx + IDX_W'(1);
      end
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Saturating error counters; clear beats a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_corr_count   <= '0;
      r_uncorr_count <= '0;
    end else if (clr_counts) begin
      r_corr_count   <= '0;
      r_uncorr_count <= '0;
    end else if (w_accept) begin
      if (w_dec_corr && (r_corr_count != CNT_MAX)) begin
        r_corr_count <= r_corr_count + CNT_W'(1);
      end
      if (w_dec_uncorr && (r_uncorr_count != CNT_MAX)) begin
        r_uncorr_count <= r_uncorr_count + CNT_W'(1);
      end
    end
  end

  // Sticky alarm; a new uncorrectable symbol beats a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alarm <= 1'b0;
    end else if (w_accept && w_dec_uncorr) begin
      r_alarm <= 1'b1;
    end else if (clr_counts) begin
      r_alarm <= 1'b0;
    end
  end

  assign out_data      = r_out_data;
  assign out_valid     = r_out_valid;
  assign out_corrected = r_out_corr;
  assign out_uncorr    = r_out_uncorr;
  assign corr_count    = r_corr_count;
  assign uncorr_count  = r_uncorr_count;
  assign uncorr_alarm  = r_alarm;

endmodule

`default_nettype wire
